// File: rtl/sys_lsu.sv
// Load/store unit in front of sys_memory: turns byte-addressed requests into word
// reads/writes, merging sub-word stores by read-modify-write, and returns extended load data.
module sys_lsu #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 1024,
  parameter int TAG_W  = 4,
  localparam int AW    = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_fault,
  output logic [TAG_W-1:0] resp_tag,
  output logic [AW-1:0]    mem_read_addr,
  output logic             mem_read_enable,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_read_valid,
  input  logic             mem_read_done,
  output logic [AW-1:0]    mem_write_addr,
  output logic             mem_write_enable,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic             mem_write_valid,
  input  logic             mem_write_done
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       lane_reg;
  logic [1:0]       size_reg;
  logic             store_reg;
  logic             unsigned_reg;
  logic [15:0]      wdata_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic             fault_reg, fault_next;
  logic             mem_read_enable_reg, mem_write_enable_reg;
  logic [AW-1:0]    mem_addr_reg;
  logic [31:0]      mem_write_data_reg, mem_write_data_next;

  logic             accept;
  logic             req_fault;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      load_ext;
  logic [31:0]      merged;

  assign accept = req_valid && (state_reg == IDLE);

  assign req_fault = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ({2'b00, req_addr[31:2]} >= 32'(LENGTH));

  assign byte_lane = mem_read_data[{lane_reg, 3'b000} +: 8];
  assign half_lane = mem_read_data[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_read_data;
    case (size_reg)
      2'b00:   load_ext = unsigned_reg ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = unsigned_reg ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_ext = mem_read_data;
    endcase
  end

  // Per byte lane: take store data when the lane is covered by the access, else keep the read word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      logic lane_hit;
      assign lane_hit = ((size_reg == 2'b00) && (lane_reg == 2'(gi))) ||
                        ((size_reg == 2'b01) && (lane_reg[1] == gi[1]));
      assign merged[8*gi +: 8] = !lane_hit ? mem_read_data[8*gi +: 8] :
                                 (size_reg == 2'b00) ? wdata_reg[7:0] : wdata_reg[8*(gi%2) +: 8];
    end
  endgenerate

  always_comb begin
    state_next          = state_reg;
    rdata_next          = rdata_reg;
    fault_next          = fault_reg;
    mem_write_data_next = mem_write_data_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          rdata_next = 32'b0;
          fault_next = req_fault;
          if (req_fault) begin
            state_next = RESP;
          end else if (req_store && (req_size == 2'b10)) begin
            state_next          = WR_ISSUE;
            mem_write_data_next = req_wdata;
          end else begin
            state_next = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (mem_read_done) begin
          if (!mem_read_valid) begin
            fault_next = 1'b1;
            state_next = RESP;
          end else if (store_reg) begin
            mem_write_data_next = merged;
            state_next          = WR_ISSUE;
          end else begin
            rdata_next = load_ext;
            state_next = RESP;
          end
        end
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT: begin
        if (mem_write_done) begin
          fault_next = !mem_write_valid;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg            <= IDLE;
      lane_reg             <= '0;
      size_reg             <= '0;
      store_reg            <= 1'b0;
      unsigned_reg         <= 1'b0;
      wdata_reg            <= '0;
      tag_reg              <= '0;
      rdata_reg            <= '0;
      fault_reg            <= 1'b0;
      mem_read_enable_reg  <= 1'b0;
      mem_write_enable_reg <= 1'b0;
      mem_addr_reg         <= '0;
      mem_write_data_reg   <= '0;
    end else begin
      state_reg            <= state_next;
      rdata_reg            <= rdata_next;
      fault_reg            <= fault_next;
      mem_write_data_reg   <= mem_write_data_next;
      mem_read_enable_reg  <= (state_next == RD_ISSUE);
      mem_write_enable_reg <= (state_next == WR_ISSUE);
      if (accept) begin
        lane_reg     <= req_addr[1:0];
        size_reg     <= req_size;
        store_reg    <= req_store;
        unsigned_reg <= req_unsigned;
        wdata_reg    <= req_wdata[15:0];
        tag_reg      <= req_tag;
        mem_addr_reg <= req_addr[AW+1:2];
      end
    end
  end

  // Ready is gated by reset so nothing is accepted while the unit is held in reset.
  assign req_ready        = (state_reg == IDLE) && rst;
  assign resp_valid       = (state_reg == RESP);
  assign resp_rdata       = rdata_reg;
  assign resp_fault       = fault_reg;
  assign resp_tag         = tag_reg;
  assign mem_read_addr    = mem_addr_reg;
  assign mem_write_addr   = mem_addr_reg;
  assign mem_read_enable  = mem_read_enable_reg;
  assign mem_write_enable = mem_write_enable_reg;
  assign mem_write_data   = mem_write_data_reg;

endmodule

// File: tb/tb_sys_lsu.sv
// Directed bench for sys_lsu with a one-cycle-latency word memory model.
module tb_sys_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [3:0]  resp_tag;
  logic [9:0]  mem_read_addr;
  logic        mem_read_enable;
  logic [31:0] mem_read_data = '0;
  logic        mem_read_valid = 1'b0;
  logic        mem_read_done = 1'b0;
  logic [9:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_write_valid = 1'b0;
  logic        mem_write_done;
  logic        wdone_q = 1'b0;
  logic        late_done = 1'b0;
  logic        rd_bad = 1'b0;

  logic [31:0] mem [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sys_lsu #(.WIDTH(32), .LENGTH(1024), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_tag(resp_tag),
    .mem_read_addr(mem_read_addr), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_read_done(mem_read_done),
    .mem_write_addr(mem_write_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_write_valid(mem_write_valid),
    .mem_write_done(mem_write_done)
  );

  assign mem_write_done = wdone_q | late_done;

  // Memory answers one cycle after it samples an enable.
  always @(posedge clk) begin
    mem_read_done   <= mem_read_enable;
    mem_read_valid  <= mem_read_enable && !rd_bad;
    wdone_q         <= mem_write_enable;
    mem_write_valid <= mem_write_enable;
    if (mem_read_enable) begin
      mem_read_data <= mem[mem_read_addr];
      rd_cnt        <= rd_cnt + 1;
    end
    if (mem_write_enable) begin
      mem[mem_write_addr] <= mem_write_data;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic xact(input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] tg,
                      output logic [31:0] rd, output logic flt, output logic [3:0] rtg,
                      output int lat);
    int n;
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_tag = tg; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; flt = resp_fault; rtg = resp_tag;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    logic [3:0]  rtg;
    int          lat;
    int          rc, wc, n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_rd_en", {31'b0, mem_read_enable}, 32'h0);
    chk("rst_wr_en", {31'b0, mem_write_enable}, 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);

    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'h3, rd, flt, rtg, lat);
    chk("sw_fault", {31'b0, flt}, 32'h0);
    chk("sw_lat", lat, 3);
    chk("sw_tag", {28'b0, rtg}, 32'h3);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);

    xact(0, 2'b10, 0, 32'h10, 32'h0, 4'h5, rd, flt, rtg, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_fault", {31'b0, flt}, 32'h0);
    chk("lw_lat", lat, 3);
    chk("lw_tag", {28'b0, rtg}, 32'h5);

    xact(1, 2'b10, 0, 32'h10, 32'h11223344, 4'h1, rd, flt, rtg, lat);
    xact(1, 2'b10, 0, 32'h14, 32'h0BADF00D, 4'h1, rd, flt, rtg, lat);
    rc = rd_cnt; wc = wr_cnt;
    xact(1, 2'b00, 0, 32'h13, 32'h000000A5, 4'h7, rd, flt, rtg, lat);
    chk("sb_lat", lat, 5);
    chk("sb_reads", rd_cnt - rc, 1);
    chk("sb_writes", wr_cnt - wc, 1);
    chk("sb_mem4", mem[4], 32'hA5223344);
    chk("sb_fault", {31'b0, flt}, 32'h0);

    xact(0, 2'b00, 0, 32'h13, 32'h0, 4'h2, rd, flt, rtg, lat);
    chk("lb_signed", rd, 32'hFFFFFFA5);
    xact(0, 2'b00, 1, 32'h13, 32'h0, 4'h2, rd, flt, rtg, lat);
    chk("lbu", rd, 32'h000000A5);
    xact(0, 2'b00, 1, 32'h11, 32'h0, 4'h2, rd, flt, rtg, lat);
    chk("lbu_lane1", rd, 32'h00000033);

    xact(1, 2'b10, 0, 32'h10, 32'h80017FFF, 4'h1, rd, flt, rtg, lat);
    xact(0, 2'b01, 0, 32'h12, 32'h0, 4'h4, rd, flt, rtg, lat);
    chk("lh_hi", rd, 32'hFFFF8001);
    xact(0, 2'b01, 0, 32'h10, 32'h0, 4'h4, rd, flt, rtg, lat);
    chk("lh_lo", rd, 32'h00007FFF);
    xact(1, 2'b01, 0, 32'h12, 32'h0000BEEF, 4'h6, rd, flt, rtg, lat);
    chk("sh_mem4", mem[4], 32'hBEEF7FFF);
    chk("sh_lat", lat, 5);

    rc = rd_cnt; wc = wr_cnt;
    xact(0, 2'b10, 0, 32'h11, 32'h0, 4'h8, rd, flt, rtg, lat);
    chk("mis_fault", {31'b0, flt}, 32'h1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_lat", lat, 1);
    chk("mis_tag", {28'b0, rtg}, 32'h8);
    xact(0, 2'b10, 0, 32'h1000, 32'h0, 4'h8, rd, flt, rtg, lat);
    chk("oor_fault", {31'b0, flt}, 32'h1);
    xact(1, 2'b11, 0, 32'h10, 32'h0, 4'h8, rd, flt, rtg, lat);
    chk("size3_fault", {31'b0, flt}, 32'h1);
    xact(1, 2'b01, 0, 32'h11, 32'h0, 4'h8, rd, flt, rtg, lat);
    chk("mish_fault", {31'b0, flt}, 32'h1);
    chk("fault_no_rd", rd_cnt - rc, 0);
    chk("fault_no_wr", wr_cnt - wc, 0);

    rd_bad = 1'b1;
    xact(0, 2'b10, 0, 32'h10, 32'h0, 4'h9, rd, flt, rtg, lat);
    rd_bad = 1'b0;
    chk("rdinv_fault", {31'b0, flt}, 32'h1);
    chk("rdinv_rdata", rd, 32'h0);

    // Backpressure: response held while a second request waits.
    @(negedge clk);
    req_store = 0; req_size = 2'b10; req_unsigned = 0;
    req_addr = 32'h10; req_tag = 4'h9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h14; req_tag = 4'hA;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, resp_valid}, 32'h1);
      chk("bp_rdata", resp_rdata, 32'hBEEF7FFF);
      chk("bp_tag", {28'b0, resp_tag}, 32'h9);
      chk("bp_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, req_ready}, 32'h1);
    chk("bp_idle_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp2_rdata", resp_rdata, 32'h0BADF00D);
    chk("bp2_tag", {28'b0, resp_tag}, 32'hA);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset while waiting for a sub-word store's write completion.
    @(negedge clk);
    req_store = 1; req_size = 2'b01; req_addr = 32'h20; req_wdata = 32'h1234;
    req_tag = 4'hC; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_write_enable && n < 20) begin @(posedge clk); #1; n++; end
    chk("rw_wr_issue", {31'b0, mem_write_enable}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("rw_ready0", {31'b0, req_ready}, 32'h0);
    chk("rw_valid0", {31'b0, resp_valid}, 32'h0);
    chk("rw_wr_en0", {31'b0, mem_write_enable}, 32'h0);
    chk("rw_wdata0", mem_write_data, 32'h0);
    chk("rw_tag0", {28'b0, resp_tag}, 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rw_ready1", {31'b0, req_ready}, 32'h1);
    @(negedge clk); late_done = 1'b1;
    @(negedge clk); late_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rw_no_resp", {31'b0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    xact(0, 2'b10, 0, 32'h10, 32'h0, 4'hD, rd, flt, rtg, lat);
    chk("rw_lw_rdata", rd, 32'hBEEF7FFF);
    chk("rw_lw_lat", lat, 3);
    chk("rw_lw_tag", {28'b0, rtg}, 32'hD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
